// File: rtl/ncc_window_feeder.sv
// ncc_window_feeder: converts signed pixels to log2 sign-magnitude words
// and shifts one window of them into the NCC array with load strobes.
module ncc_window_feeder #(
    parameter int windowSize = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pixelIn,
    input  logic        pixelValid,
    output logic        pixelReady,
    input  logic        enable,
    output logic [32:0] windowOut,
    output logic        loadWinReg,
    output logic        loadAccSumReg,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(windowSize + 1);
    localparam logic [CW-1:0] WS = CW'(windowSize);
    localparam logic [CW-1:0] WS_M1 = CW'(windowSize - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_inCount;
    logic [CW-1:0] r_outCount;
    logic          r_s1Valid;
    logic          r_s1Sign;
    logic [31:0]   r_s1Mag;
    logic          r_s2Valid;
    logic [32:0]   r_s2Word;
    logic          r_lacc;
    logic          r_last;
    logic          w_adv;
    logic          w_accept;
    logic          w_lw;
    logic [31:0]   w_mag;
    logic [4:0]    w_idx;
    logic [31:0]   w_norm;
    logic [32:0]   w_word;

    assign w_adv      = !r_s2Valid || enable;
    assign pixelReady = (r_state == STREAM) && (r_inCount < WS)
                        && (!r_s1Valid || w_adv);
    assign w_accept   = pixelValid && pixelReady;
    assign w_lw       = r_s2Valid && enable;
    assign w_mag      = pixelIn[31] ? (~pixelIn + 32'd1) : pixelIn;

    assign windowOut     = r_s2Word;
    assign loadWinReg    = w_lw;
    assign loadAccSumReg = r_lacc;
    assign busy          = (r_state != IDLE);
    assign done          = r_last;

    // Normalise magnitude: leading-one position and truncated fraction
    always_comb begin
        w_idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_s1Mag[i]) w_idx = 5'(i);
        end
        w_norm = r_s1Mag << (5'd31 - w_idx);
        w_word = (r_s1Mag == 32'd0) ? 33'd0
                 : {r_s1Sign, w_idx, w_norm[30:4]};
    end

    // Window framing state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: start opens, full input count drains, done closes
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = STREAM;
            STREAM:  if (r_inCount == WS) w_next = DRAIN;
            DRAIN:   if (r_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Input and output counters, saturating at the window size
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inCount  <= '0;
            r_outCount <= '0;
        end else if (r_state == IDLE && start) begin
            r_inCount  <= '0;
            r_outCount <= '0;
        end else begin
            if (w_accept && r_inCount != WS)
                r_inCount <= r_inCount + 1'b1;
            if (w_lw && r_outCount != WS)
                r_outCount <= r_outCount + 1'b1;
        end
    end

    // Stage1: capture sign and magnitude of an accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Sign  <= 1'b0;
            r_s1Mag   <= 32'd0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Sign  <= pixelIn[31];
            r_s1Mag   <= w_mag;
        end else if (w_adv) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage2: register the log word; holds while the array stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Word  <= 33'd0;
        end else if (w_adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) r_s2Word <= w_word;
        end
    end

    // Accumulate strobe trails the shift strobe; last one flags done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lacc <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_lacc <= w_lw;
            r_last <= w_lw && (r_outCount == WS_M1);
        end
    end
endmodule

// File: tb/tb_ncc_window_feeder.sv
// tb_ncc_window_feeder: randomized checks of the window feeder
// against a plain-arithmetic log-domain model.
module tb_ncc_window_feeder;
    localparam int WS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pixelIn = 32'd0;
    logic        pixelValid = 1'b0;
    logic        pixelReady;
    logic        enable = 1'b1;
    logic [32:0] windowOut;
    logic        loadWinReg;
    logic        loadAccSumReg;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic stall_on = 1'b0;

    logic [31:0] px_q[$];
    logic [32:0] got_q[$];
    int acc_cyc[$];
    int lw_cyc[$];
    int la_cyc[$];
    int done_cyc[$];
    logic [32:0] st_wo[$];
    logic st_rdy[$];
    logic st_lw[$];

    always #5 clk = ~clk;

    ncc_window_feeder #(.windowSize(WS)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pixelIn(pixelIn),
        .pixelValid(pixelValid),
        .pixelReady(pixelReady),
        .enable(enable),
        .windowOut(windowOut),
        .loadWinReg(loadWinReg),
        .loadAccSumReg(loadAccSumReg),
        .busy(busy),
        .done(done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (pixelValid && pixelReady) acc_cyc.push_back(cyc);
            if (loadWinReg) begin
                lw_cyc.push_back(cyc);
                got_q.push_back(windowOut);
            end
            if (loadAccSumReg) la_cyc.push_back(cyc);
            if (done) done_cyc.push_back(cyc);
            if (stall_on) begin
                st_wo.push_back(windowOut);
                st_rdy.push_back(pixelReady);
                st_lw.push_back(loadWinReg);
            end
        end
    end

    function automatic logic [32:0] model(input logic [31:0] p);
        longint v, mag, f;
        int idx;
        logic [4:0] e;
        v = longint'($signed(p));
        mag = (v < 0) ? -v : v;
        if (mag == 0) return 33'd0;
        idx = 0;
        while ((longint'(1) << (idx + 1)) <= mag) idx++;
        f = ((mag - (longint'(1) << idx)) << 27) >> idx;
        e = idx[4:0];
        return {p[31], e, f[26:0]};
    endfunction

    task automatic clear_logs();
        got_q.delete(); acc_cyc.delete(); lw_cyc.delete();
        la_cyc.delete(); done_cyc.delete();
        st_wo.delete(); st_rdy.delete(); st_lw.delete();
    endtask

    // mode bit0: random valid gaps, bit1: enable stall, bit2: extra starts
    task automatic run_window(input int mode, output int s_cyc);
        int i;
        int n;
        logic [31:0] m;
        m = mode;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; pixelValid = 1'b0; enable = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        n = 0;
        while (done_cyc.size() == 0 && n < 200) begin
            pixelValid = (i < px_q.size())
                         && (!m[0] || $urandom_range(0, 3) != 0);
            pixelIn = (i < px_q.size()) ? px_q[i] : $urandom;
            enable = !(m[1] && n >= 3 && n < 8);
            stall_on = !enable;
            start = m[2] && (n % 3 == 1);
            @(negedge clk);
            if (pixelValid && pixelReady) i++;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; pixelValid = 1'b0; enable = 1'b1; stall_on = 1'b0;
        total++;
        if (done_cyc.size() == 0) begin
            bad++;
            $display("FAIL done_timeout got=none want=done within 200");
        end
    endtask

    task automatic fill_random();
        px_q.delete();
        for (int k = 0; k < WS; k++) px_q.push_back($urandom);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({pixelReady, loadWinReg, loadAccSumReg, busy, done} !== 5'b0
            || windowOut !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h want=0/0",
                {pixelReady, loadWinReg, loadAccSumReg, busy, done},
                windowOut);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_conversion();
        int s;
        px_q.delete();
        px_q.push_back(32'd0);
        px_q.push_back(32'd1);
        px_q.push_back(32'd3);
        px_q.push_back(32'hFFFF_FFF8);
        px_q.push_back(32'h8000_0000);
        px_q.push_back(32'h7FFF_FFFF);
        px_q.push_back($urandom);
        px_q.push_back($urandom);
        run_window(1, s);
        total++;
        if (model(32'd3) !== {1'b0, 5'd1, 27'h4000000}) begin
            bad++;
            $display("FAIL conv_model3 got=%h want=%h", model(32'd3),
                {1'b0, 5'd1, 27'h4000000});
        end
        total++;
        if (got_q.size() != WS) begin
            bad++;
            $display("FAIL conv_count got=%0d want=%0d", got_q.size(), WS);
        end
        for (int k = 0; k < WS; k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== model(px_q[k])) begin
                bad++;
                $display("FAIL conv_word[%0d] px=%h got=%h want=%h", k,
                    px_q[k], (k < got_q.size()) ? got_q[k] : 33'hx,
                    model(px_q[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        fill_random();
        run_window(0, s);
        total++;
        if (acc_cyc.size() != WS || lw_cyc.size() != WS
            || la_cyc.size() != WS || done_cyc.size() != 1) begin
            bad++;
            $display("FAIL b2b_counts got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/1",
                acc_cyc.size(), lw_cyc.size(), la_cyc.size(),
                done_cyc.size(), WS, WS, WS);
        end else begin
            for (int k = 0; k < WS; k++) begin
                total++;
                if (acc_cyc[k] - s != k + 1 || lw_cyc[k] - s != k + 3
                    || la_cyc[k] - s != k + 4) begin
                    bad++;
                    $display("FAIL b2b_timing[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d",
                        k, acc_cyc[k] - s, lw_cyc[k] - s, la_cyc[k] - s,
                        k + 1, k + 3, k + 4);
                end
                total++;
                if (got_q[k] !== model(px_q[k])) begin
                    bad++;
                    $display("FAIL b2b_word[%0d] got=%h want=%h", k,
                        got_q[k], model(px_q[k]));
                end
            end
            total++;
            if (done_cyc[0] - s != WS + 3) begin
                bad++;
                $display("FAIL b2b_done got=%0d want=%0d",
                    done_cyc[0] - s, WS + 3);
            end
        end
        total++;
        if (pixelReady !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_after_done got=rdy%b busy%b want=rdy0 busy0",
                pixelReady, busy);
        end
    endtask

    task automatic test_stall();
        int s;
        fill_random();
        run_window(2, s);
        total++;
        if (st_rdy.size() != 5) begin
            bad++;
            $display("FAIL stall_len got=%0d want=5", st_rdy.size());
        end else begin
            total++;
            if (st_rdy[2] !== 1'b0 || st_rdy[4] !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready got=%b%b want=00",
                    st_rdy[2], st_rdy[4]);
            end
            for (int k = 0; k < 5; k++) begin
                total++;
                if (st_wo[k] !== st_wo[0] || st_lw[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_hold[%0d] got=%h lw%b want=%h lw0",
                        k, st_wo[k], st_lw[k], st_wo[0]);
                end
            end
        end
        total++;
        if (got_q.size() != WS || la_cyc.size() != WS) begin
            bad++;
            $display("FAIL stall_strobes got=%0d/%0d want=%0d", got_q.size(),
                la_cyc.size(), WS);
        end
        for (int k = 0; k < WS; k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== model(px_q[k])) begin
                bad++;
                $display("FAIL stall_word[%0d] got=%h want=%h", k,
                    (k < got_q.size()) ? got_q[k] : 33'hx, model(px_q[k]));
            end
        end
        total++;
        if (done_cyc.size() != 1 || la_cyc.size() == 0
            || done_cyc[0] != la_cyc[la_cyc.size() - 1]) begin
            bad++;
            $display("FAIL stall_done got=%0d want=1 on last acc strobe",
                done_cyc.size());
        end
    endtask

    task automatic test_redundant_start();
        int s;
        fill_random();
        run_window(5, s);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (done_cyc.size() != 1 || got_q.size() != WS) begin
            bad++;
            $display("FAIL restart_counts got=done%0d lw%0d want=done1 lw%0d",
                done_cyc.size(), got_q.size(), WS);
        end
        for (int k = 0; k < WS; k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== model(px_q[k])) begin
                bad++;
                $display("FAIL restart_word[%0d] got=%h want=%h", k,
                    (k < got_q.size()) ? got_q[k] : 33'hx, model(px_q[k]));
            end
        end
    endtask

    task automatic test_reset_midwindow();
        int s;
        int n;
        fill_random();
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (acc_cyc.size() < 3 && n < 50) begin
            pixelValid = 1'b1;
            pixelIn = px_q[acc_cyc.size()];
            @(posedge clk); #1;
            n++;
        end
        pixelValid = 1'b0;
        total++;
        if (acc_cyc.size() != 3) begin
            bad++;
            $display("FAIL rstmid_accepts got=%0d want=3", acc_cyc.size());
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pixelReady, loadWinReg, loadAccSumReg, busy, done} !== 5'b0
            || windowOut !== 33'd0) begin
            bad++;
            $display("FAIL rstmid_clear got=%b/%h want=0/0",
                {pixelReady, loadWinReg, loadAccSumReg, busy, done},
                windowOut);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        pixelValid = 1'b1;
        repeat (6) @(posedge clk);
        #1 pixelValid = 1'b0;
        total++;
        if (lw_cyc.size() + la_cyc.size() + done_cyc.size()
            + acc_cyc.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet got=%0d events busy%b want=0 busy0",
                lw_cyc.size() + la_cyc.size() + done_cyc.size()
                + acc_cyc.size(), busy);
        end
        fill_random();
        run_window(1, s);
        total++;
        if (got_q.size() != WS || done_cyc.size() != 1) begin
            bad++;
            $display("FAIL rstmid_rerun got=lw%0d done%0d want=lw%0d done1",
                got_q.size(), done_cyc.size(), WS);
        end
        for (int k = 0; k < WS; k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== model(px_q[k])) begin
                bad++;
                $display("FAIL rstmid_word[%0d] got=%h want=%h", k,
                    (k < got_q.size()) ? got_q[k] : 33'hx, model(px_q[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_back_to_back();
        test_stall();
        test_redundant_start();
        test_reset_midwindow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
